// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the SPI initiator: FSM state encoding and
// phase-counter sizing.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;

  // Below four clk cycles per half-period the minion's synchronizer cannot keep up.
  localparam int SCLK_HALF_MIN = 4;

  function automatic int phase_cnt_width(input int sclk_half);
    return (sclk_half <= 2) ? 1 : $clog2(sclk_half);
  endfunction

endpackage

// File: rtl/spi_master_shift_reg.sv
// N-bit shift register with parallel load and left shift (serial in at LSB,
// serial out from MSB).
module spi_master_shift_reg #(
  parameter int N = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift,
  input  logic         ser_in,
  output logic [N-1:0] q,
  output logic         ser_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[N-2:0], ser_in};
  end

  assign ser_out = q[N-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI initiator: one frame per val/rdy request, MSB first, captured
// miso frame returned on a val/rdy response port.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int NBITS        = 34,
  parameter int SCLK_HALF    = 4,
  parameter int CS_ADDR_BITS = 1,
  localparam int NUM_CS      = 2 ** CS_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CS_ADDR_BITS+NBITS-1:0] recv_msg,
  input  logic                      recv_val,
  output logic                      recv_rdy,
  output logic [NBITS-1:0]          send_msg,
  output logic                      send_val,
  input  logic                      send_rdy,
  output logic [NUM_CS-1:0]         cs,
  output logic                      sclk,
  output logic                      mosi,
  input  logic [NUM_CS-1:0]         miso
);

  localparam int PW = phase_cnt_width(SCLK_HALF);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  if (SCLK_HALF < SCLK_HALF_MIN) begin : g_bad_sclk_half
    $error("spi_master_ctrl: SCLK_HALF below minimum of 4");
  end

  state_t                  state;
  logic [PW-1:0]           phase;
  logic [BW-1:0]           bit_cnt;
  logic [CS_ADDR_BITS-1:0] cs_idx;
  logic [NBITS-1:0]        rx_q;
  logic [NBITS-1:0]        unused_tx_q;
  logic                    unused_rx_msb;
  logic                    accept, sample_edge, phase_end, miso_bit;

  assign accept      = (state == IDLE) && recv_val && recv_rdy;
  assign phase_end   = (phase == '0);
  assign sample_edge = (state == HIGH) && phase_end;
  assign miso_bit    = miso[cs_idx];

  // mosi comes straight from the tx MSB flop; the frame drains to zero by HOLD.
  spi_master_shift_reg #(.N(NBITS)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (recv_msg[NBITS-1:0]),
    .shift    (sample_edge),
    .ser_in   (1'b0),
    .q        (unused_tx_q),
    .ser_out  (mosi)
  );

  spi_master_shift_reg #(.N(NBITS)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .shift    (sample_edge),
    .ser_in   (miso_bit),
    .q        (rx_q),
    .ser_out  (unused_rx_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      cs_idx   <= '0;
      cs       <= '1;
      sclk     <= 1'b0;
      recv_rdy <= 1'b0;
      send_val <= 1'b0;
      send_msg <= '0;
    end else begin
      case (state)
        IDLE: begin
          recv_rdy <= 1'b1;
          if (accept) begin
            cs_idx   <= recv_msg[NBITS +: CS_ADDR_BITS];
            cs       <= ~(NUM_CS'(1) << recv_msg[NBITS +: CS_ADDR_BITS]);
            recv_rdy <= 1'b0;
            phase    <= PHASE_LAST;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            phase <= PHASE_LAST;
            sclk  <= 1'b1;
            state <= HIGH;
          end else phase <= phase - 1'b1;
        end
        HIGH: begin
          if (phase_end) begin
            phase <= PHASE_LAST;
            sclk  <= 1'b0;
            state <= LOW;
          end else phase <= phase - 1'b1;
        end
        LOW: begin
          if (phase_end) begin
            phase <= PHASE_LAST;
            if (bit_cnt == BIT_LAST) begin
              cs    <= '1;
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b1;
              state   <= HIGH;
            end
          end else phase <= phase - 1'b1;
        end
        HOLD: begin
          if (phase_end) begin
            send_msg <= rx_q;
            state    <= DONE;
          end else phase <= phase - 1'b1;
        end
        DONE: begin
          send_val <= 1'b1;
          if (send_val && send_rdy) begin
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: timing-level reference model plus
// directed and randomized transactions (loopback on index 0, minion on index 1).
module tb_spi_master_ctrl;
  localparam int NB     = 34;
  localparam int LAT    = 281;
  localparam int CS_LOW = 276;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB:0]   recv_msg = '0;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic [NB-1:0] send_msg;
  logic          send_val;
  logic          send_rdy = 1'b1;
  logic [1:0]    cs;
  logic          sclk, mosi;
  logic [1:0]    miso;

  always #5 clk = ~clk;

  spi_master_ctrl #(.NBITS(NB), .SCLK_HALF(4), .CS_ADDR_BITS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  // Minion on index 1 shifts out minion_frame (updates on sclk fall); index 0 loops mosi back.
  logic [NB-1:0] minion_frame = '0;
  logic [NB-1:0] m_shift = '0;
  always @(negedge cs[1]) m_shift = minion_frame;
  always @(negedge sclk) if (!cs[1]) m_shift = {m_shift[NB-2:0], 1'b0};
  assign miso = {m_shift[NB-1], mosi};

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int bp_left = 0;
  bit rand_mode = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_left > 0) begin
      send_rdy = 1'b0;
      if (send_val) bp_left--;
    end else send_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Reference model: expected waveform as a function of cycles since accept.
  bit            m_busy = 0, rdy_ok = 0, val_seen = 0;
  int            acc_edge = 0, dut_resps = 0, exp_resps = 0;
  logic          m_idx = 1'b0;
  logic [NB-1:0] m_frame = '0, m_resp = '0, last_resp = '0;
  int            cs0_low = 0, cs1_low = 0, rises = 0, hi_run = 0;
  logic          sclk_prev = 1'b0;
  int            last_lat = 0, last_val_edge = 0, last_cs0 = 0, last_cs1 = 0;
  int            last_rises = 0, last_gap = 0, acc_after_val = 0;

  always @(negedge clk) begin
    int k;
    logic [1:0] e_cs;
    logic e_sclk, e_mosi, e_val, e_rdy;
    if (reset) begin
      chk("rst_cs", 64'(cs), 64'h3);
      chk("rst_sclk", 64'(sclk), 64'h0);
      chk("rst_mosi", 64'(mosi), 64'h0);
      chk("rst_send_val", 64'(send_val), 64'h0);
      chk("rst_recv_rdy", 64'(recv_rdy), 64'h0);
      chk("rst_send_msg", 64'(send_msg), 64'h0);
      m_busy = 0; rdy_ok = 0; val_seen = 0; sclk_prev = 1'b0; hi_run = 0;
    end else begin
      k = m_busy ? cyc - acc_edge : 0;
      if (m_busy) begin
        e_cs   = (k < CS_LOW) ? ~(2'b01 << m_idx) : 2'b11;
        e_sclk = (k >= 4 && k < CS_LOW) ? (((k - 4) % 8) < 4) : 1'b0;
        e_mosi = (k / 8 < NB) ? m_frame[NB-1-(k/8)] : 1'b0;
        e_val  = (k >= LAT);
        e_rdy  = 1'b0;
      end else begin
        e_cs = 2'b11; e_sclk = 1'b0; e_mosi = 1'b0; e_val = 1'b0; e_rdy = rdy_ok;
      end
      chk("cs", 64'(cs), 64'(e_cs));
      chk("sclk", 64'(sclk), 64'(e_sclk));
      chk("mosi", 64'(mosi), 64'(e_mosi));
      chk("send_val", 64'(send_val), 64'(e_val));
      chk("recv_rdy", 64'(recv_rdy), 64'(e_rdy));
      if (e_val) chk("send_msg", 64'(send_msg), 64'(m_resp));

      if (!cs[0]) cs0_low++;
      if (!cs[1]) cs1_low++;
      if (sclk && !sclk_prev) rises++;
      sclk_prev = sclk;
      if (cs == 2'b11) hi_run++; else hi_run = 0;
      if (send_val && !val_seen) begin
        val_seen = 1; last_lat = k; last_val_edge = cyc;
      end
      if (send_val && send_rdy) begin
        dut_resps++; last_resp = send_msg; val_seen = 0;
        last_cs0 = cs0_low; last_cs1 = cs1_low; last_rises = rises;
      end

      if (!m_busy) begin
        if (rdy_ok && recv_val) begin
          m_busy = 1; acc_edge = cyc + 1;
          m_idx = recv_msg[NB]; m_frame = recv_msg[NB-1:0];
          m_resp = recv_msg[NB] ? minion_frame : recv_msg[NB-1:0];
          last_gap = hi_run; acc_after_val = cyc + 1 - last_val_edge;
          cs0_low = 0; cs1_low = 0; rises = 0;
        end else rdy_ok = 1;
      end else if (k >= LAT && send_rdy) begin
        m_busy = 0; rdy_ok = 1;
      end
    end
  end

  task automatic send_req(input logic idx, input logic [NB-1:0] frame);
    int t = 0;
    recv_msg = {idx, frame};
    recv_val = 1'b1;
    forever begin
      @(negedge clk);
      if (recv_rdy) break;
      t++;
      if (t > 2000) begin
        chk("accept_timeout", 64'(recv_rdy), 64'h1);
        break;
      end
    end
    @(posedge clk); #1;
    recv_val = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((dut_resps != exp_resps || m_busy) && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, 64'(dut_resps), 64'(exp_resps));
  endtask

  initial begin
    logic [NB-1:0] f;
    logic          idx;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_hold", 64'(cs), 64'h3);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", 64'(recv_rdy), 64'h1);

    send_req(1'b0, 34'h2DEADBEEF); exp_resps++;
    wait_done("loopback_count");
    chk("lb_resp", 64'(last_resp), 64'h2DEADBEEF);
    chk("lb_latency", 64'(last_lat), 64'd281);
    chk("lb_cs0_low", 64'(last_cs0), 64'd276);
    chk("lb_cs1_low", 64'(last_cs1), 64'd0);
    chk("lb_sclk_rises", 64'(last_rises), 64'd34);

    minion_frame = 34'h1A5C30F96;
    send_req(1'b1, 34'h012345678); exp_resps++;
    wait_done("minion_count");
    chk("mn_resp", 64'(last_resp), 64'h1A5C30F96);
    chk("mn_cs1_low", 64'(last_cs1), 64'd276);
    chk("mn_cs0_low", 64'(last_cs0), 64'd0);

    bp_left = 50;
    send_req(1'b0, 34'h30F0F0F0F); exp_resps++;
    send_req(1'b0, 34'h000000001); exp_resps++;
    chk("bp_accept_gap", 64'(acc_after_val), 64'd52);
    wait_done("bp_count");
    chk("bp_resp2", 64'(last_resp), 64'h000000001);

    send_req(1'b0, 34'h155555555);
    send_req(1'b0, 34'h2AAAAAAAA); exp_resps += 2;
    chk("b2b_gap_ge6", 64'(last_gap >= 6), 64'h1);
    wait_done("b2b_count");
    chk("b2b_latency2", 64'(last_lat), 64'd281);
    chk("b2b_resp2", 64'(last_resp), 64'h2AAAAAAAA);

    send_req(1'b0, 34'h2AAAA5555);
    repeat (85) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_cs", 64'(cs), 64'h3);
    chk("async_sclk", 64'(sclk), 64'h0);
    chk("async_mosi", 64'(mosi), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_no_resp", 64'(dut_resps), 64'(exp_resps));
    send_req(1'b0, 34'h123456789); exp_resps++;
    wait_done("post_abort_count");
    chk("post_abort_resp", 64'(last_resp), 64'h123456789);

    rand_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f[31:0]  = $urandom;
      f[33:32] = 2'($urandom_range(0, 3));
      idx = 1'($urandom_range(0, 1));
      minion_frame[31:0]  = $urandom;
      minion_frame[33:32] = 2'($urandom_range(0, 3));
      send_req(idx, f); exp_resps++;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_done("random_count");
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
